// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for asynchronous inputs; flops come out of reset high,
// matching an idle serial line.
module sync_ff2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle done strobe per good byte,
// sticky framing error, and break handling so a held-low line yields no bytes.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cfg
            $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    logic                 rx_s;
    rx_state_t            state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shreg_reg, shreg_next;
    logic [7:0]           data_reg, data_next;
    logic                 done_reg, done_next;
    logic                 ferr_reg, ferr_next;

    sync_ff2 #(.WIDTH(1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shreg_next   = shreg_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        ferr_next    = ferr_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        // Start bit did not survive to mid-point: treat as a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next                = '0;
                    shreg_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shreg_reg;
                        done_next  = 1'b1;
                        ferr_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK_WAIT;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            BREAK_WAIT: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shreg_reg   <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shreg_reg   <= shreg_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            ferr_reg    <= ferr_next;
        end
    end

    assign rx_data   = data_reg;
    assign rx_done   = done_reg;
    assign rx_busy   = (state_reg != IDLE);
    assign frame_err = ferr_reg;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: reset, good frames,
// back-to-back frames, glitch rejection, framing error/break, mid-frame reset.
module tb_uart_rx_byte;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int checks = 0;
    int fails  = 0;

    int         cyc = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    int         prev_done_cyc = 0;
    int         consec_cnt = 0;
    logic       done_prev = 1'b0;
    logic [7:0] done_data_q[$];

    int fall_cyc;
    int base_done;

    uart_rx_byte #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count posedges so the stimulus can timestamp events in clock edges.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc;
            done_data_q.push_back(rx_data);
            if (done_prev) consec_cnt <= consec_cnt + 1;
        end
        done_prev <= rx_done;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        // 1. Reset
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", rx_busy, 1'b0);
        check("post_rst_done_cnt", done_cnt, 0);

        // 2. Single frame 0xA5: done strobe follows edge 155 after the fall
        fall_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_done_cnt", done_cnt, 1);
        check("a5_done_time", last_done_cyc - fall_cyc, 155);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_frame_err", frame_err, 1'b0);
        check("a5_busy_idle", rx_busy, 1'b0);
        $display("a5 frame: rx_data=%02h done_cnt=%0d", rx_data, done_cnt);

        // 3. Back-to-back 0x00 then 0xFF
        fall_cyc = cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        check("b2b_done_cnt", done_cnt, 3);
        check("b2b_spacing", last_done_cyc - prev_done_cyc, 160);
        check("b2b_first_time", prev_done_cyc - fall_cyc, 155);
        check("b2b_data0", done_data_q[1], 8'h00);
        check("b2b_data1", done_data_q[2], 8'hFF);
        check("b2b_rx_data", rx_data, 8'hFF);
        $display("b2b frames: rx_data=%02h done_cnt=%0d", rx_data, done_cnt);

        // 4. Glitch: 4 low cycles, rejected at the start-bit mid-point
        base_done = done_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_rise", rx_busy, 1'b1);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_busy_fall", rx_busy, 1'b0);
        repeat (30) @(negedge clk);
        check("glitch_no_done", done_cnt, base_done);
        check("glitch_rx_data", rx_data, 8'hFF);
        $display("glitch: busy=%0b done_cnt=%0d", rx_busy, done_cnt);

        // 5. Framing error on 0x3C followed by a held-low break
        base_done = done_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_flag", frame_err, 1'b1);
        check("ferr_busy_break", rx_busy, 1'b1);
        check("ferr_no_done", done_cnt, base_done);
        check("ferr_rx_data", rx_data, 8'hFF);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_busy_release", rx_busy, 1'b0);
        check("ferr_sticky", frame_err, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        check("ferr_recover_done", done_cnt, base_done + 1);
        check("ferr_recover_data", rx_data, 8'h55);
        check("ferr_cleared", frame_err, 1'b0);
        $display("frame error: rx_data=%02h frame_err=%0b", rx_data, frame_err);

        // 6. Reset pulse in the middle of data bit 4
        base_done = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_done", rx_done, 1'b0);
        check("midrst_rx_busy", rx_busy, 1'b0);
        check("midrst_frame_err", frame_err, 1'b0);
        repeat (200) @(negedge clk);
        check("midrst_idle_no_done", done_cnt, base_done);
        check("midrst_idle_busy", rx_busy, 1'b0);
        send_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        check("midrst_81_done", done_cnt, base_done + 1);
        check("midrst_81_data", rx_data, 8'h81);
        $display("mid-frame reset: rx_data=%02h done_cnt=%0d", rx_data, done_cnt);

        check("never_consecutive_done", consec_cnt, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Receives 8N1 asynchronous serial frames on the UART RX pin and presents each received byte with a one-cycle done strobe. It sits directly upstream of address_counterN. rx_done drives the counter's d strobe, so the counter advances once per received byte while rx_data is written into instruction RAM at the current address. Framing errors are flagged and never strobe the counter.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, serial bit rate in bits/s
CLKS_PER_BIT (localparam), CLK_FREQ/BAUD (integer division), clocks per bit; elaboration $error if < 4
HALF_BIT (localparam), CLKS_PER_BIT/2, start-bit mid-point offset

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-low reset (0 = reset)
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  last correctly framed byte
rx_done  output  1  one-cycle pulse when rx_data updates
rx_busy  output  1  high whenever FSM is not IDLE
frame_err  output  1  sticky framing-error flag

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, counters 0, sync flops=1, rx_data=0x00, rx_done=0, rx_busy=0, frame_err=0. Reset has priority over all else, including mid-frame.
- rx passes through a 2-flop synchronizer (both reset to 1); the FSM uses only the synchronized value rx_s.
- E0 = the edge at which IDLE sees rx_s==0; this is the 3rd clk edge after the pin falls.
- IDLE: cnt=0. On rx_s==0 go to START.
- START: cnt increments each cycle. At cnt==HALF_BIT-1 (edge E0+HALF_BIT):
  - rx_s==0: go to DATA, cnt=0, bit_idx=0.
  - rx_s==1: glitch; return to IDLE, no outputs change.
- DATA: at cnt==CLKS_PER_BIT-1, set shreg[bit_idx]<=rx_s (LSB first) and cnt=0. If bit_idx==7 go to STOP, else bit_idx++.
  - Bit k (k=0..7) is sampled at E0+HALF_BIT+(k+1)*CLKS_PER_BIT.
- STOP: sample taken at E0+HALF_BIT+9*CLKS_PER_BIT.
  - rx_s==1: rx_data<=shreg, rx_done=1 for exactly the following cycle, frame_err<=0, go to IDLE.
  - rx_s==0: frame_err<=1, rx_data unchanged, no rx_done, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line being decoded as 0x00 frames.
- rx_busy is high in START, DATA, STOP and BREAK_WAIT.
- Back-to-back frames: a new start bit may begin immediately after the stop-bit sample and must be received. The next E0 is at the earliest the edge after the return to IDLE.
- Counter widths: cnt is $clog2(CLKS_PER_BIT) bits and never exceeds CLKS_PER_BIT-1; bit_idx is 3 bits.
- rx_done is never asserted for two consecutive cycles. The downstream edge detector therefore counts exactly one increment per byte.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} rx_state_t
  - localparam DATA_BITS=8
- Sub-module sync_ff2: 2-flop synchronizer with clk, rst (active-low sync) and reset value 1. It is reused by future UART TX/handshake inputs.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16 and HALF_BIT=8.
1. rst=0 for 3 cycles, rx=1 -> rx_data=0x00, rx_done=0, rx_busy=0, frame_err=0; state stays IDLE after release.
2. Send 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1), each bit 16 cycles -> rx_done high for exactly the one cycle after edge 155 counted from the pin fall, rx_data=0xA5, frame_err=0.
3. Send 0x00 then 0xFF with no idle gap -> two single-cycle rx_done pulses 160 cycles apart, rx_data 0x00 then 0xFF. An address_counterN on rx_done advances by exactly 2.
4. Glitch: rx=0 for 4 cycles, then 1 -> rx_busy falls within 11 cycles of the pin fall, no rx_done, rx_data unchanged.
5. Send 0x3C with stop bit 0, then hold rx=0 for 40 more cycles, then 1 -> frame_err=1, no rx_done, rx_data holds its prior value, rx_busy stays high until rx_s returns to 1. A following good frame 0x55 gives rx_done, rx_data=0x55 and clears frame_err.
6. Assert rst=0 for 1 cycle during data bit 4 of a frame -> next cycle all outputs at reset values, state IDLE. The subsequent frame 0x81 is received correctly with a single rx_done.
